// File: rtl/accel_bus_port.sv
// Accelerator-side responder for the CPU<->accelerator bus.
// The CPU writes command and payload words. Payload words are buffered in an
// input FIFO and streamed to the core over a valid/ready handshake. Results
// from the core are queued in an output FIFO and read back on bus_rdata.
//
// state | meaning
// IDLE  | accepting command words
// LOAD  | bus writes are payload words, counted down by the length field
// RUN   | core running; collecting results until core_done
module accel_bus_port #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_wr_en,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rd_en,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic              bus_busy,
    output logic [DATA_W-1:0] core_wdata,
    output logic              core_wvalid,
    input  logic              core_wready,
    output logic              core_start,
    input  logic [DATA_W-1:0] core_rdata,
    input  logic              core_rvalid,
    input  logic              core_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_START = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [DATA_W-1:0] in_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0] out_mem [FIFO_DEPTH];
    logic [AW-1:0]     in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [AW-1:0]     out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [CW-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

    logic [3:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_push_req, in_push, in_pop;
    logic              out_push_req, out_push, out_pop;
    logic              flush, overflow;
    logic [7:0]        in_cnt8;
    logic [15:0]       status;

    assign cmd_op  = bus_wdata[DATA_W-1 -: 4];
    assign cmd_len = bus_wdata[LEN_W-1:0];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign in_pop       = (in_cnt_q != '0) && core_wready;
    assign in_push_req  = bus_wr_en && (state_q == ST_LOAD);
    assign in_push      = in_push_req && ((in_cnt_q < CW'(FIFO_DEPTH)) || in_pop);
    assign out_pop      = bus_rd_en && (out_cnt_q != '0);
    assign out_push_req = core_rvalid;
    assign out_push     = out_push_req && ((out_cnt_q < CW'(FIFO_DEPTH)) || out_pop);
    assign overflow     = (in_push_req && !in_push) || (out_push_req && !out_push);

    // CLEAR in IDLE and the abort in RUN use the same opcode.
    assign flush = bus_wr_en && (cmd_op == OP_CLEAR) &&
                   ((state_q == ST_IDLE) || (state_q == ST_RUN));

    assign in_cnt8 = 8'(in_cnt_q);
    assign status  = {1'b1, state_q, err_q, 4'b0000, in_cnt8};

    assign bus_rvalid  = (out_cnt_q != '0);
    assign bus_rdata   = bus_rvalid ? out_mem[out_rptr_q] : DATA_W'(status);
    assign bus_busy    = (state_q != ST_IDLE);
    assign core_wvalid = (in_cnt_q != '0);
    assign core_wdata  = in_mem[in_rptr_q];
    assign core_start  = start_q;

    // Next-state for the sequencing FSM and error flag.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        start_d = 1'b0;
        len_d   = len_q;
        if (overflow) err_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus_wr_en) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            if (cmd_len != '0) begin
                                state_d = ST_LOAD;
                                len_d   = cmd_len;
                            end
                        end
                        OP_START: begin
                            start_d = 1'b1;
                            state_d = ST_RUN;
                        end
                        OP_CLEAR: err_d = 1'b0;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                // Dropped words still count against the length.
                if (bus_wr_en) begin
                    len_d = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (core_done) state_d = ST_IDLE;
                if (bus_wr_en) begin
                    if (cmd_op == OP_CLEAR) begin
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-state for FIFO pointers and occupancy counts.
    always_comb begin
        in_wptr_d  = in_wptr_q + AW'(in_push);
        in_rptr_d  = in_rptr_q + AW'(in_pop);
        in_cnt_d   = in_cnt_q + CW'(in_push) - CW'(in_pop);
        out_wptr_d = out_wptr_q + AW'(out_push);
        out_rptr_d = out_rptr_q + AW'(out_pop);
        out_cnt_d  = out_cnt_q + CW'(out_push) - CW'(out_pop);
        if (flush) begin
            in_wptr_d  = '0;
            in_rptr_d  = '0;
            in_cnt_d   = '0;
            out_wptr_d = '0;
            out_rptr_d = '0;
            out_cnt_d  = '0;
        end
    end

    // Control and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            len_q      <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            start_q    <= start_d;
            len_q      <= len_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until covered by the count.
    always_ff @(posedge clk) begin
        if (in_push && !flush) in_mem[in_wptr_q] <= bus_wdata;
        if (out_push && !flush) out_mem[out_wptr_q] <= core_rdata;
    end

endmodule

// File: tb/tb_accel_bus_port.sv
// Directed bench for accel_bus_port with hand-computed expected values.
module tb_accel_bus_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_wr_en;
    logic [15:0] bus_wdata;
    logic        bus_rd_en;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_busy;
    logic [15:0] core_wdata;
    logic        core_wvalid;
    logic        core_wready;
    logic        core_start;
    logic [15:0] core_rdata;
    logic        core_rvalid;
    logic        core_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accel_bus_port #(.DATA_W(16), .FIFO_DEPTH(8), .LEN_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_wr_en  (bus_wr_en),
        .bus_wdata  (bus_wdata),
        .bus_rd_en  (bus_rd_en),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .bus_busy   (bus_busy),
        .core_wdata (core_wdata),
        .core_wvalid(core_wvalid),
        .core_wready(core_wready),
        .core_start (core_start),
        .core_rdata (core_rdata),
        .core_rvalid(core_rvalid),
        .core_done  (core_done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] w);
        bus_wr_en = 1'b1;
        bus_wdata = w;
        tick();
        bus_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus_wr_en   = 1'b0;
        bus_wdata   = '0;
        bus_rd_en   = 1'b0;
        core_wready = 1'b0;
        core_rdata  = '0;
        core_rvalid = 1'b0;
        core_done   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // 1: reset state
        check("rst_rdata",  bus_rdata,   16'h8000);
        check("rst_rvalid", bus_rvalid,  16'd0);
        check("rst_busy",   bus_busy,    16'd0);
        check("rst_wvalid", core_wvalid, 16'd0);
        check("rst_start",  core_start,  16'd0);

        // 2: LOAD three words, then drain them to the core
        wr(16'h1003);
        check("load_busy0", bus_busy, 16'd1);
        wr(16'h00AA);
        check("load_busy1", bus_busy, 16'd1);
        wr(16'h00BB);
        wr(16'h00CC);
        check("load_status", bus_rdata, 16'h8003);
        check("load_idle",   bus_busy,  16'd0);
        core_wready = 1'b1;
        check("drain0", core_wdata, 16'h00AA);
        tick();
        check("drain1", core_wdata, 16'h00BB);
        tick();
        check("drain2", core_wdata, 16'h00CC);
        check("drain2_v", core_wvalid, 16'd1);
        tick();
        check("drain_empty", core_wvalid, 16'd0);

        // 3: START, results, readback
        wr(16'h2000);
        check("start_pulse", core_start, 16'd1);
        check("run_status",  bus_rdata,  16'hC000);
        tick();
        check("start_once",  core_start, 16'd0);
        core_rvalid = 1'b1;
        core_rdata  = 16'h1234;
        tick();
        core_rdata = 16'h5678;
        core_done  = 1'b1;
        tick();
        core_rvalid = 1'b0;
        core_done   = 1'b0;
        check("done_busy",  bus_busy,   16'd0);
        check("res_valid",  bus_rvalid, 16'd1);
        check("res0",       bus_rdata,  16'h1234);
        bus_rd_en = 1'b1;
        tick();
        check("res1", bus_rdata, 16'h5678);
        tick();
        check("res_empty", bus_rdata, 16'h8000);
        check("res_rvalid0", bus_rvalid, 16'd0);
        tick();
        check("rd_empty_noop", bus_rdata, 16'h8000);
        bus_rd_en = 1'b0;

        // 4: overflow with core stalled, then CLEAR
        core_wready = 1'b0;
        wr(16'h1009);
        for (int i = 0; i < 9; i++) wr(16'(16'h0100 + i));
        check("ovf_status", bus_rdata, 16'h9008);
        check("ovf_head",   core_wdata, 16'h0100);
        wr(16'h3000);
        check("clear_status", bus_rdata,   16'h8000);
        check("clear_wvalid", core_wvalid, 16'd0);

        // 5: illegal op, write during RUN, abort
        wr(16'h7000);
        check("badop_err", bus_rdata, 16'h9000);
        wr(16'h2000);
        check("run_err", bus_rdata, 16'hD000);
        wr(16'h1001);
        check("run_wr_ignored", bus_rdata, 16'hD000);
        wr(16'h3000);
        check("abort_status", bus_rdata, 16'h8000);
        check("abort_busy",   bus_busy,  16'd0);

        // 6: reset mid-LOAD and mid-RUN
        wr(16'h1004);
        wr(16'h0001);
        wr(16'h0002);
        check("midload_status", bus_rdata, 16'hA002);
        do_reset();
        check("rst_load_status", bus_rdata,   16'h8000);
        check("rst_load_wvalid", core_wvalid, 16'd0);
        wr(16'h2000);
        core_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_rdata = 16'(16'h0A00 + i);
            tick();
        end
        core_rvalid = 1'b0;
        check("midrun_head", bus_rdata, 16'h0A00);
        check("midrun_busy", bus_busy,  16'd1);
        do_reset();
        check("rst_run_rvalid", bus_rvalid, 16'd0);
        check("rst_run_status", bus_rdata,  16'h8000);
        check("rst_run_busy",   bus_busy,   16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
